// File: rtl/fpw_pkg.sv
// -----------------------------------------------------------------------------
// fpw_pkg: shared definitions for the frame pattern writer.
//   - state_t    : writer FSM states
//   - MODE_*     : pattern select encodings (iMODE)
//   - pixel_t    : 16-bit pixel, red in the high byte, blue in the low byte
//   - DEF_*      : default frame geometry
// -----------------------------------------------------------------------------
package fpw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_GRAD  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] blue;
  } pixel_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

endpackage

// File: rtl/fpw_pixel_gen.sv
// -----------------------------------------------------------------------------
// fpw_pixel_gen: purely combinational pattern generator.
//   i_x      [9:0]  effective column (already offset when scrolling is on)
//   i_y      [9:0]  row
//   i_mode   [1:0]  latched pattern select (MODE_*)
//   i_solid  [15:0] latched solid colour
//   o_pixel  [15:0] {red, blue}
// -----------------------------------------------------------------------------
module fpw_pixel_gen
  import fpw_pkg::*;
#(
  parameter int BAR_W      = 80,
  parameter int CHECK_LOG2 = 5
) (
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  input  logic [1:0]  i_mode,
  input  logic [15:0] i_solid,
  output logic [15:0] o_pixel
);

  logic [2:0] w_bar;
  logic [7:0] w_bar_lvl;
  pixel_t     w_pix;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_bar     = 3'd0;
    w_pix     = '0;
    // Bar index x/BAR_W built from a comparator chain rather than a divider.
    for (int k = 1; k < 8; k++) begin
      if (i_x >= 10'(k * BAR_W)) w_bar = w_bar + 3'd1;
    end
    // Upper four bars are half intensity.
    w_bar_lvl = w_bar[2] ? 8'h7F : 8'hFF;

    case (i_mode)
      MODE_BARS: begin
        w_pix.red  = w_bar[0] ? w_bar_lvl : 8'h00;
        w_pix.blue = w_bar[1] ? w_bar_lvl : 8'h00;
      end
      MODE_GRAD: begin
        w_pix.red  = i_x[9:2];
        w_pix.blue = i_y[8:1];
      end
      MODE_CHECK: begin
        w_pix = (i_x[CHECK_LOG2] ^ i_y[CHECK_LOG2]) ? 16'hFFFF : 16'h0000;
      end
      default: begin
        w_pix = i_solid;
      end
    endcase
  end

  assign o_pixel = w_pix;

endmodule

// File: rtl/frame_pattern_writer.sv
// -----------------------------------------------------------------------------
// frame_pattern_writer: fills the SDRAM frame buffer with one raster-order
// frame of test-pattern pixels through the write-side FIFO.
//
// Ports:
//   iCLK         write-side clock (FIFO write clock domain)
//   iRST         synchronous active-high reset
//   iSTART       one-cycle start pulse, ignored while busy
//   iCONT        continuous mode, sampled at end of frame
//   iMODE  [1:0] pattern select (bars, gradient, checker, solid)
//   iSOLID [15:0] solid-mode colour
//   iWR_FULL     FIFO full flag (registered inside the FIFO)
//   oWR_EN       write strobe, one pixel per cycle while high
//   oWR_DATA [15:0] pixel {R8,B8}
//   oBUSY        high whenever not idle
//   oFRAME_DONE  one-cycle pulse after the last pixel is accepted
//   oX, oY [9:0] current column / row
//
// Optional build macro FRAME_PATTERN_ANIMATE_EN: adds a horizontal offset that
// advances 8 pixels per frame so bars and checker scroll left.
// -----------------------------------------------------------------------------
module frame_pattern_writer
  import fpw_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int BAR_W      = 80,
  parameter int CHECK_LOG2 = 5
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iCONT,
  input  logic [1:0]  iMODE,
  input  logic [15:0] iSOLID,
  input  logic        iWR_FULL,
  output logic        oWR_EN,
  output logic [15:0] oWR_DATA,
  output logic        oBUSY,
  output logic        oFRAME_DONE,
  output logic [9:0]  oX,
  output logic [9:0]  oY
);

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [1:0]  r_mode;
  logic [15:0] r_solid;
  logic        w_accept;
  logic        w_last_pixel;
  logic [9:0]  w_x_eff;

  // The FIFO flag is already registered, so the strobe may follow it directly.
  assign w_accept     = (r_state == FILL) && !iWR_FULL;
  assign w_last_pixel = w_accept && (r_x == X_LAST) && (r_y == Y_LAST);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (iSTART) w_next_state = LOAD;
      LOAD: w_next_state = FILL;
      FILL: if (w_last_pixel) w_next_state = DONE;
      DONE: w_next_state = iCONT ? LOAD : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (iRST) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_mode  <= MODE_BARS;
      r_solid <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == LOAD) begin
        r_x     <= '0;
        r_y     <= '0;
        r_mode  <= iMODE;
        r_solid <= iSOLID;
      end else if (w_accept) begin
        if (r_x == X_LAST) begin
          r_x <= '0;
          // Row holds on the final line; FILL exits on that same edge.
          if (r_y != Y_LAST) r_y <= r_y + 10'd1;
        end else begin
          r_x <= r_x + 10'd1;
        end
      end
    end
  end

`ifdef FRAME_PATTERN_ANIMATE_EN
  logic [9:0]  r_offset;
  logic [10:0] w_x_sum;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_offset <= '0;
    end else if (r_state == DONE) begin
      // Advance by 8, wrapping at the line width.
      if (r_offset >= 10'(H_ACTIVE - 8)) r_offset <= r_offset - 10'(H_ACTIVE - 8);
      else                                r_offset <= r_offset + 10'd8;
    end
  end

  always_comb begin
    w_x_sum = {1'b0, r_x} + {1'b0, r_offset};
    w_x_eff = w_x_sum[9:0];
    if (w_x_sum >= 11'(H_ACTIVE)) w_x_eff = 10'(w_x_sum - 11'(H_ACTIVE));
  end
`else
  assign w_x_eff = r_x;
`endif

  fpw_pixel_gen #(
    .BAR_W      (BAR_W),
    .CHECK_LOG2 (CHECK_LOG2)
  ) u_pixel_gen (
    .i_x     (w_x_eff),
    .i_y     (r_y),
    .i_mode  (r_mode),
    .i_solid (r_solid),
    .o_pixel (oWR_DATA)
  );

  assign oWR_EN      = w_accept;
  assign oBUSY       = (r_state != IDLE);
  assign oFRAME_DONE = (r_state == DONE);
  assign oX          = r_x;
  assign oY          = r_y;

endmodule
